alu_operand_stage: RTL

Issue/operand-fetch stage directly upstream of the 32-bit ALU. Accepts decoded operation packets, reads an internal flop-based register file, applies immediate and bypass selection, and presents a registered `{alu_sel, op_a, op_b}` bundle to the ALU with a valid/ready handshake. A per-register pending scoreboard stalls issue until downstream writeback retires each destination. Writeback arrives on a separate port from the result stage after the ALU.

---
 rtl/alu_operand_stage.sv | 107 ++++++++++
 1 files changed

// File: rtl/alu_operand_stage.sv
// Operand-fetch/issue stage feeding the 32-bit ALU.
// Owns the register file, bypass muxes and the pending scoreboard.
module alu_operand_stage #(
  parameter int NREG = 8,
  parameter int DATA_W = 32,
  localparam int RW = $clog2(NREG)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_op,
  input  logic [RW-1:0]     in_rd,
  input  logic [RW-1:0]     in_rs1,
  input  logic [RW-1:0]     in_rs2,
  input  logic              in_use_imm,
  input  logic [11:0]       in_imm,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [3:0]        alu_sel,
  output logic [DATA_W-1:0] op_a,
  output logic [DATA_W-1:0] op_b,
  output logic [RW-1:0]     out_rd,
  input  logic              wb_en,
  input  logic [RW-1:0]     wb_rd,
  input  logic [DATA_W-1:0] wb_data,
  output logic              busy
);

  logic [DATA_W-1:0] regs [NREG];
  logic [NREG-1:0]   pend;
  logic [NREG-1:0]   wb_hot;
  logic [NREG-1:0]   set_hot;
  logic [NREG-1:0]   pend_eff;
  logic [DATA_W-1:0] src1;
  logic [DATA_W-1:0] src2;
  logic [DATA_W-1:0] imm_ext;
  logic              haz1;
  logic              haz2;
  logic              haz_rd;
  logic              hazard;
  logic              accept;

  assign imm_ext  = {{(DATA_W-12){in_imm[11]}}, in_imm};
  assign wb_hot   = wb_en ? (NREG'(1) << wb_rd) : '0;
  assign pend_eff = pend & ~wb_hot;

  always_comb begin
    src1 = '0;
    if (in_rs1 != '0) begin
      if (wb_en && wb_rd == in_rs1) src1 = wb_data;
      else                          src1 = regs[in_rs1];
    end
  end

  always_comb begin
    src2 = '0;
    if (in_use_imm) begin
      src2 = imm_ext;
    end else if (in_rs2 != '0) begin
      if (wb_en && wb_rd == in_rs2) src2 = wb_data;
      else                          src2 = regs[in_rs2];
    end
  end

  assign haz1   = (in_rs1 != '0) && pend_eff[in_rs1];
  assign haz2   = !in_use_imm && (in_rs2 != '0) && pend_eff[in_rs2];
  assign haz_rd = (in_rd != '0) && pend_eff[in_rd];
  assign hazard = haz1 || haz2 || haz_rd;

  assign in_ready = !rst && (!out_valid || out_ready) && !hazard;
  assign accept   = in_valid && in_ready;
  assign set_hot  = (accept && in_rd != '0) ? (NREG'(1) << in_rd) : '0;
  assign busy     = |pend;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      alu_sel   <= '0;
      op_a      <= '0;
      op_b      <= '0;
      out_rd    <= '0;
      pend      <= '0;
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else begin
      if (wb_en && wb_rd != '0) regs[wb_rd] <= wb_data;
      // OR-ing the new set after the clear lets a same-cycle issue win
      pend <= (pend & ~wb_hot) | set_hot;
      if (accept) begin
        out_valid <= 1'b1;
        alu_sel   <= in_op;
        out_rd    <= in_rd;
        // ALU computes B - A for sub, so swap to get rs1 - rs2
        if (in_op == 4'b0001) begin
          op_a <= src2;
          op_b <= src1;
        end else begin
          op_a <= src1;
          op_b <= src2;
        end
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule
